// File: rtl/writepixels.sv
// writepixels: byte-serial transmitter for the PMOD LED-array driver.
// Each accepted byte is framed as START, eight LSB-first data bits
// (clock low then clock high per bit) and a three-phase stop sequence,
// with every phase lasting CLK_DIV system clocks.
//
// Handshake: the byte on value is taken at a rising CLK edge where
// valid=1 and busy=0. busy rises on that same edge and falls on the edge
// that ends the frame. Requests made while busy=1 are dropped, not queued.
module writepixels #(
    parameter int CLK_DIV = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       valid,
    input  logic [7:0] value,
    output logic       o_sclk,
    output logic       o_sdata,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        BIT_LO = 3'd2,
        BIT_HI = 3'd3,
        STOP_A = 3'd4,
        STOP_B = 3'd5,
        STOP_C = 3'd6
    } state_t;

    // Terminal count of the phase counter; a phase is CLK_DIV cycles long.
    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] phase_q, phase_d;
    logic [2:0] bit_q,   bit_d;
    logic [7:0] shift_q, shift_d;
    logic       sclk_d,  sdata_d, busy_d;
    logic       phase_end;
    logic [2:0] bit_nxt;

    assign phase_end = (phase_q == PHASE_LAST);
    assign bit_nxt   = bit_q + 3'd1;

    // State, counters, shift register and the registered line levels.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            phase_q <= 8'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            o_sclk  <= 1'b1;
            o_sdata <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            o_sclk  <= sclk_d;
            o_sdata <= sdata_d;
            busy    <= busy_d;
        end
    end

    // Next state plus the line levels of the state being entered, so the
    // outputs only move on phase boundaries and never glitch.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        sclk_d  = o_sclk;
        sdata_d = o_sdata;
        busy_d  = busy;

        if (state_q == IDLE) begin
            phase_d = 8'd0;
            sclk_d  = 1'b1;
            sdata_d = 1'b1;
            busy_d  = 1'b0;
            if (valid) begin
                shift_d = value;
                state_d = START;
                busy_d  = 1'b1;
                sdata_d = 1'b0;
            end
        end else if (!phase_end) begin
            phase_d = phase_q + 8'd1;
        end else begin
            phase_d = 8'd0;
            case (state_q)
                START: begin
                    state_d = BIT_LO;
                    sclk_d  = 1'b0;
                    sdata_d = shift_q[bit_q];
                end
                BIT_LO: begin
                    state_d = BIT_HI;
                    sclk_d  = 1'b1;
                end
                BIT_HI: begin
                    sclk_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        // Bit index wraps only here, at the end of the byte.
                        state_d = STOP_A;
                        bit_d   = 3'd0;
                        sdata_d = 1'b0;
                    end else begin
                        state_d = BIT_LO;
                        bit_d   = bit_nxt;
                        sdata_d = shift_q[bit_nxt];
                    end
                end
                STOP_A: begin
                    state_d = STOP_B;
                    sclk_d  = 1'b1;
                    sdata_d = 1'b0;
                end
                STOP_B: begin
                    state_d = STOP_C;
                    sclk_d  = 1'b1;
                    sdata_d = 1'b1;
                end
                STOP_C: begin
                    state_d = IDLE;
                    sclk_d  = 1'b1;
                    sdata_d = 1'b1;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    bit_d   = 3'd0;
                    sclk_d  = 1'b1;
                    sdata_d = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writepixels.sv
// Bench for writepixels: one instance at CLK_DIV=4 and one at CLK_DIV=1.
// A line monitor per instance decodes frames from the two pins (start,
// bits on sclk rising edges, stop) into a queue of received bytes.
module tb_writepixels;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       valid4 = 1'b0;
    logic       valid1 = 1'b0;
    logic [7:0] value4 = 8'h00;
    logic [7:0] value1 = 8'h00;
    logic       sclk4, sdata4, busy4;
    logic       sclk1, sdata1, busy1;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got4_q[$];
    logic [7:0] got1_q[$];

    // Clock and reset block
    always #5 CLK = ~CLK;

    writepixels #(.CLK_DIV(4)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .valid(valid4), .value(value4),
        .o_sclk(sclk4), .o_sdata(sdata4), .busy(busy4)
    );

    writepixels #(.CLK_DIV(1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .valid(valid1), .value(value1),
        .o_sclk(sclk1), .o_sdata(sdata1), .busy(busy1)
    );

    // Line monitor for the CLK_DIV=4 instance. Nine sclk rising edges per
    // frame: eight data bits plus the one entering STOP_B.
    logic       m4_sclk_p = 1'b1, m4_sdata_p = 1'b1;
    logic [7:0] m4_sh = 8'h00;
    int         m4_cnt = 0;
    always @(negedge CLK) begin
        if (!RST_N) begin
            m4_cnt     <= 0;
            m4_sclk_p  <= 1'b1;
            m4_sdata_p <= 1'b1;
        end else begin
            if (sclk4 && m4_sclk_p && m4_sdata_p && !sdata4) begin
                m4_cnt <= 0;
            end else if (sclk4 && !m4_sclk_p) begin
                if (m4_cnt < 8) m4_sh[m4_cnt] <= sdata4;
                m4_cnt <= m4_cnt + 1;
            end else if (sclk4 && m4_sclk_p && !m4_sdata_p && sdata4) begin
                if (m4_cnt == 9) got4_q.push_back(m4_sh);
                m4_cnt <= 0;
            end
            m4_sclk_p  <= sclk4;
            m4_sdata_p <= sdata4;
        end
    end

    // Line monitor for the CLK_DIV=1 instance.
    logic       m1_sclk_p = 1'b1, m1_sdata_p = 1'b1;
    logic [7:0] m1_sh = 8'h00;
    int         m1_cnt = 0;
    always @(negedge CLK) begin
        if (!RST_N) begin
            m1_cnt     <= 0;
            m1_sclk_p  <= 1'b1;
            m1_sdata_p <= 1'b1;
        end else begin
            if (sclk1 && m1_sclk_p && m1_sdata_p && !sdata1) begin
                m1_cnt <= 0;
            end else if (sclk1 && !m1_sclk_p) begin
                if (m1_cnt < 8) m1_sh[m1_cnt] <= sdata1;
                m1_cnt <= m1_cnt + 1;
            end else if (sclk1 && m1_sclk_p && !m1_sdata_p && sdata1) begin
                if (m1_cnt == 9) got1_q.push_back(m1_sh);
                m1_cnt <= 0;
            end
            m1_sclk_p  <= sclk1;
            m1_sdata_p <= sdata1;
        end
    end

    // Driver: present a byte to the CLK_DIV=4 instance for one cycle.
    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send4(input logic [7:0] v);
        valid4 = 1'b1;
        value4 = v;
        @(negedge CLK);
        valid4 = 1'b0;
    endtask

    // Counts negedges with busy4 high, starting at the current one.
    task automatic count_busy4(output int n);
        n = 0;
        while (busy4 && n < 1000) begin
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            tests_run++;
            if ({sclk4, sdata4, busy4, sclk1, sdata1, busy1} !== 6'b110110) begin
                tests_failed++;
                $display("FAIL reset_hold: got %b required 110110",
                         {sclk4, sdata4, busy4, sclk1, sdata1, busy1});
            end
        end
        #2 RST_N = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            tests_run++;
            if ({sclk4, sdata4, busy4, sclk1, sdata1, busy1} !== 6'b110110) begin
                tests_failed++;
                $display("FAIL reset_release_idle: got %b required 110110",
                         {sclk4, sdata4, busy4, sclk1, sdata1, busy1});
            end
        end
    endtask

    task automatic test_single_byte();
        int n;
        got4_q = {};
        @(negedge CLK);
        send4(8'hF1);
        tests_run++;
        if ({busy4, sclk4, sdata4} !== 3'b110) begin
            tests_failed++;
            $display("FAIL single_start: busy/sclk/sdata got %b required 110",
                     {busy4, sclk4, sdata4});
        end
        count_busy4(n);
        tests_run++;
        if (n != 80) begin
            tests_failed++;
            $display("FAIL single_busy_len: got %0d required 80", n);
        end
        repeat (3) @(negedge CLK);
        tests_run++;
        if (got4_q.size() != 1 || got4_q[0] !== 8'hF1) begin
            tests_failed++;
            $display("FAIL single_byte: got %0d bytes first %h required 1 byte f1",
                     got4_q.size(), (got4_q.size() > 0) ? got4_q[0] : 8'hxx);
        end
        tests_run++;
        if ({sclk4, sdata4} !== 2'b11) begin
            tests_failed++;
            $display("FAIL single_end_lines: got %b required 11", {sclk4, sdata4});
        end
    endtask

    task automatic test_sequencer();
        int waited;
        got4_q = {};
        exp_q  = {};
        exp_q.push_back(8'hF1);
        for (int i = 0; i < 16; i++) exp_q.push_back((i % 2 == 0) ? 8'h00 : 8'h55);
        for (int i = 0; i < exp_q.size(); i++) begin
            waited = 0;
            while ((busy4 || valid4) && waited < 200) begin
                @(negedge CLK);
                waited++;
            end
            tests_run++;
            if (busy4 || valid4) begin
                tests_failed++;
                $display("FAIL seq_wait_idle: busy=%b after %0d cycles required 0",
                         busy4, waited);
            end
            send4(exp_q[i]);
        end
        waited = 0;
        while (busy4 && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        repeat (3) @(negedge CLK);
        tests_run++;
        if (got4_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL seq_count: got %0d frames required %0d",
                     got4_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (i >= got4_q.size() || got4_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL seq_byte[%0d]: got %h required %h", i,
                         (i < got4_q.size()) ? got4_q[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int idle;
        got4_q = {};
        @(negedge CLK);
        valid4 = 1'b1;
        value4 = 8'h3C;
        @(negedge CLK);
        value4 = 8'hC3;
        n = 0;
        while (busy4 && n < 200) begin
            n++;
            @(negedge CLK);
        end
        tests_run++;
        if (n != 80) begin
            tests_failed++;
            $display("FAIL b2b_busy_len: got %0d required 80", n);
        end
        idle = 0;
        while (!busy4 && idle < 10) begin
            idle++;
            @(negedge CLK);
        end
        valid4 = 1'b0;
        tests_run++;
        if (idle != 1) begin
            tests_failed++;
            $display("FAIL b2b_idle_gap: got %0d idle cycles required 1", idle);
        end
        count_busy4(n);
        repeat (3) @(negedge CLK);
        tests_run++;
        if (got4_q.size() != 2 || got4_q[0] !== 8'h3C || got4_q[1] !== 8'hC3) begin
            tests_failed++;
            $display("FAIL b2b_bytes: got %0d bytes %h %h required 3c c3",
                     got4_q.size(),
                     (got4_q.size() > 0) ? got4_q[0] : 8'hxx,
                     (got4_q.size() > 1) ? got4_q[1] : 8'hxx);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        got4_q = {};
        @(negedge CLK);
        send4(8'h5A);
        // 29 cycles past accept lands in the clock-low phase of bit 3.
        repeat (29) @(negedge CLK);
        tests_run++;
        if ({busy4, sclk4, sdata4} !== 3'b101) begin
            tests_failed++;
            $display("FAIL mid_bit3_level: busy/sclk/sdata got %b required 101",
                     {busy4, sclk4, sdata4});
        end
        #2 RST_N = 1'b0;
        #1;
        tests_run++;
        if ({sclk4, sdata4, busy4} !== 3'b110) begin
            tests_failed++;
            $display("FAIL mid_async_reset: got %b required 110", {sclk4, sdata4, busy4});
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        send4(8'h96);
        count_busy4(n);
        tests_run++;
        if (n != 80) begin
            tests_failed++;
            $display("FAIL mid_next_busy_len: got %0d required 80", n);
        end
        repeat (3) @(negedge CLK);
        tests_run++;
        if (got4_q.size() != 1 || got4_q[0] !== 8'h96) begin
            tests_failed++;
            $display("FAIL mid_next_byte: got %0d bytes first %h required 1 byte 96",
                     got4_q.size(), (got4_q.size() > 0) ? got4_q[0] : 8'hxx);
        end
    endtask

    task automatic test_div1();
        int n;
        got1_q = {};
        @(negedge CLK);
        valid1 = 1'b1;
        value1 = 8'hA5;
        @(negedge CLK);
        valid1 = 1'b0;
        tests_run++;
        if ({busy1, sclk1, sdata1} !== 3'b110) begin
            tests_failed++;
            $display("FAIL div1_start: busy/sclk/sdata got %b required 110",
                     {busy1, sclk1, sdata1});
        end
        n = 0;
        while (busy1 && n < 200) begin
            n++;
            @(negedge CLK);
        end
        tests_run++;
        if (n != 20) begin
            tests_failed++;
            $display("FAIL div1_busy_len: got %0d required 20", n);
        end
        repeat (3) @(negedge CLK);
        tests_run++;
        if (got1_q.size() != 1 || got1_q[0] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL div1_byte: got %0d bytes first %h required 1 byte a5",
                     got1_q.size(), (got1_q.size() > 0) ? got1_q[0] : 8'hxx);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_sequencer();
        test_back_to_back();
        test_reset_mid_frame();
        test_div1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog: the whole run needs only a few thousand cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/writepixels.md
Name: writepixels

Overview:
- Byte-serial transmitter for the PMOD LED-array driver chip, using a two-wire clock/data interface.
- Accepts one 8-bit word per valid/busy handshake from the display sequencer.
- Frames the word with start and stop conditions and shifts it out LSB-first on a divided serial clock.
- Drives two PMOD pins directly: serial clock on PMOD1A[7], serial data on PMOD1A[6].

Parameters:
- CLK_DIV, 4: system-clock cycles per serial phase (half serial-clock period). Legal range 1..255.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- valid  input  1  request strobe; the word on value is taken when valid=1 and busy=0.
- value  input  8  word to transmit.
- o_sclk  output  1  serial clock to the LED driver; idles high.
- o_sdata  output  1  serial data to the LED driver; idles high.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset state: while RST_N=0, force o_sclk=1, o_sdata=1, busy=0, FSM=IDLE, phase counter=0, bit index=0.
- Reset mid-frame aborts immediately: lines return high and the byte is discarded.
- Phase timing: a phase counter counts CLK_DIV cycles. Every non-IDLE state holds for exactly one phase, then advances. Outputs are registered and change only on phase boundaries.
- Accept rule: in IDLE, when valid=1 at a rising edge:
  - latch value into the shift register;
  - set busy=1 at that same edge;
  - enter START and drive o_sdata=0 with o_sclk=1.
- Ignored requests: valid while busy=1 is ignored, with no queueing. valid=0 in IDLE keeps the lines high.
- States and line levels:
  - IDLE: sclk=1, sdata=1, busy=0.
  - START (1 phase): sclk=1, sdata=0. This is the start condition (data falls while clock is high).
  - BIT_LO (1 phase, per bit): sclk=0, sdata=shift[bit]. Bit order is LSB first, bit 0..7.
  - BIT_HI (1 phase, per bit): sclk=1, sdata held. The receiver samples on the sclk rising edge.
  - After BIT_HI of bit 7, go to STOP_A; otherwise go to BIT_LO of the next bit.
  - STOP_A (1 phase): sclk=0, sdata=0.
  - STOP_B (1 phase): sclk=1, sdata=0.
  - STOP_C (1 phase): sclk=1, sdata=1. This is the stop condition (data rises while clock is high).
  - End of STOP_C: go to IDLE with busy=0 at that edge.
- Frame length: 1 + 16 + 3 = 20 phases. busy stays high for exactly 20*CLK_DIV cycles.
- Back-to-back frames: valid asserted in the first cycle after busy falls starts a new frame. At least one IDLE cycle always separates frames.
- Upstream handshake: busy rising on the accept edge guarantees an upstream sequencer that checks "busy=0 and valid=0" before asserting valid never double-sends a byte.
- Glitch-free outputs: o_sdata changes only while o_sclk=0, except in START and STOP_C.
- Width rules: phase counter is 8 bits, bit index is 3 bits and wraps 7→0 only at the end of a frame. Value 0x00 and 0xFF need no special handling.

Test Plan:
- Reset: hold RST_N=0 for 5 cycles, including a deassert in the middle of a CLK cycle → o_sclk=1, o_sdata=1, busy=0 throughout. Release → lines stay high with valid=0.
- Single byte 0xF1, CLK_DIV=4, valid pulse of 1 cycle:
  - busy rises on the same edge and stays high 80 cycles;
  - sdata falls while sclk=1;
  - sampled bits on the 8 sclk rising edges are 1,0,0,0,1,1,1,1 (LSB first);
  - stop condition follows; lines end high.
- Sequencer sequence: header 0xF1, then 16 bytes alternating 0x00/0x55, each sent when busy=0 and valid=0 → 17 complete frames, decoded bytes match in order, none dropped or duplicated.
- valid held high continuously during a frame, value changed mid-frame → the transmitted byte equals the value latched at the accept edge; a new frame starts 1 cycle after busy falls.
- Reset asserted during bit 3 of a frame → lines high and busy=0 immediately (asynchronously). The next valid after release sends a complete correct frame.
- CLK_DIV=1, byte 0xA5 → busy high for 20 cycles; decoded bits are 1,0,1,0,0,1,0,1.
